// File: rtl/bigmul_pkg.sv
// rtl/bigmul_pkg.sv - shared constants and encodings for the BIGMUL multiplier, loader and drain
package bigmul_pkg;

    localparam int NUM_LIMBS = 64;
    localparam int LIMB_W    = 64;
    localparam int ADDR_W    = 6;

    typedef enum logic [2:0] {
        S_LOAD_A = 3'd0,
        S_PAD_A  = 3'd1,
        S_LOAD_B = 3'd2,
        S_PAD_B  = 3'd3,
        S_START  = 3'd4,
        S_WAIT   = 3'd5
    } state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/bigmul_operand_loader.sv
// rtl/bigmul_operand_loader.sv - streams A/B operand limbs into the BIGMUL limb memories and starts it
module bigmul_operand_loader
    import bigmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LIMB_W-1:0] in_data,
    input  logic              in_last,
    output logic              op_we,
    output logic              op_sel,
    output logic [ADDR_W-1:0] op_addr,
    output logic [LIMB_W-1:0] op_wdata,
    output logic [ADDR_W:0]   len_a,
    output logic [ADDR_W:0]   len_b,
    output logic              mul_start,
    input  logic              mul_done,
    output logic              loader_busy
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_LIMBS - 1);

    state_t          state;
    logic [ADDR_W:0] count;
    logic            accept;
    logic            at_last;
    logic            is_b;

    assign accept  = in_valid && in_ready;
    assign at_last = (count == LAST_IDX);
    assign is_b    = (state == S_LOAD_B) || (state == S_PAD_B);

    // Operand FSM: limb counter, write port, lengths and multiplier handshake, all registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD_A;
            count       <= '0;
            in_ready    <= 1'b0;
            op_we       <= 1'b0;
            op_sel      <= SEL_A;
            op_addr     <= '0;
            op_wdata    <= '0;
            len_a       <= '0;
            len_b       <= '0;
            mul_start   <= 1'b0;
            loader_busy <= 1'b0;
        end else begin
            op_we     <= 1'b0;
            mul_start <= 1'b0;
            case (state)
                S_LOAD_A, S_LOAD_B: begin
                    if (accept) begin
                        op_we       <= 1'b1;
                        op_sel      <= is_b ? SEL_B : SEL_A;
                        op_addr     <= count[ADDR_W-1:0];
                        op_wdata    <= in_data;
                        loader_busy <= 1'b1;
                        // The NUM_LIMBS-th beat ends the operand even without in_last
                        if (in_last || at_last) begin
                            if (is_b) len_b <= count + 1'b1;
                            else      len_a <= count + 1'b1;
                            if (!at_last) begin
                                state    <= is_b ? S_PAD_B : S_PAD_A;
                                count    <= count + 1'b1;
                                in_ready <= 1'b0;
                            end else if (!is_b) begin
                                // Full A flows straight into B without dropping ready
                                state <= S_LOAD_B;
                                count <= '0;
                            end else begin
                                state    <= S_START;
                                count    <= '0;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        // Ready comes up one cycle after entering from reset or S_WAIT
                        in_ready    <= 1'b1;
                        loader_busy <= is_b || (count != '0);
                    end
                end
                S_PAD_A, S_PAD_B: begin
                    op_we       <= 1'b1;
                    op_sel      <= is_b ? SEL_B : SEL_A;
                    op_addr     <= count[ADDR_W-1:0];
                    op_wdata    <= '0;
                    loader_busy <= 1'b1;
                    if (at_last) begin
                        count <= '0;
                        if (is_b) begin
                            state <= S_START;
                        end else begin
                            state    <= S_LOAD_B;
                            in_ready <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                S_START: begin
                    mul_start   <= 1'b1;
                    loader_busy <= 1'b1;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (mul_done) begin
                        state       <= S_LOAD_A;
                        count       <= '0;
                        loader_busy <= 1'b0;
                    end else begin
                        loader_busy <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_LOAD_A;
                    count       <= '0;
                    in_ready    <= 1'b0;
                    loader_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bigmul_operand_loader.sv
// tb/tb_bigmul_operand_loader.sv - directed self-checking bench for bigmul_operand_loader
module tb_bigmul_operand_loader;
    import bigmul_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [LIMB_W-1:0] in_data;
    logic              in_last;
    logic              op_we;
    logic              op_sel;
    logic [ADDR_W-1:0] op_addr;
    logic [LIMB_W-1:0] op_wdata;
    logic [ADDR_W:0]   len_a;
    logic [ADDR_W:0]   len_b;
    logic              mul_start;
    logic              mul_done;
    logic              loader_busy;

    bigmul_operand_loader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .op_we       (op_we),
        .op_sel      (op_sel),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .len_a       (len_a),
        .len_b       (len_b),
        .mul_start   (mul_start),
        .mul_done    (mul_done),
        .loader_busy (loader_busy)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    // Free-running cycle counter used for latency measurements
    always @(posedge clk) cyc <= cyc + 1;

    logic              mon_clr = 1'b1;
    logic [LIMB_W-1:0] a_mem [NUM_LIMBS];
    logic [LIMB_W-1:0] b_mem [NUM_LIMBS];
    int                a_wr, b_wr, a_last, b_last, order_bad, starts, start_cyc, ready_rise_cyc;
    logic              ready_prev = 1'b0;

    // Write/start monitor sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (in_ready === 1'b1 && ready_prev !== 1'b1) ready_rise_cyc = cyc;
        ready_prev = in_ready;
        if (mon_clr) begin
            a_wr = 0; b_wr = 0; a_last = -1; b_last = -1;
            order_bad = 0; starts = 0; start_cyc = 0;
            for (int k = 0; k < NUM_LIMBS; k++) begin
                a_mem[k] = 'x;
                b_mem[k] = 'x;
            end
        end else begin
            if (op_we === 1'b1) begin
                if (op_sel === SEL_A) begin
                    if (int'(op_addr) <= a_last) order_bad++;
                    a_last = int'(op_addr);
                    a_mem[op_addr] = op_wdata;
                    a_wr++;
                end else begin
                    if (int'(op_addr) <= b_last) order_bad++;
                    b_last = int'(op_addr);
                    b_mem[op_addr] = op_wdata;
                    b_wr++;
                end
            end
            if (mul_start === 1'b1) begin
                if (starts == 0) start_cyc = cyc;
                starts++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
        tick();
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input int gap, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && waited < 2000) begin
            tick();
            waited++;
        end
        if (waited >= 2000) chk("beat_ready_timeout", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_start();
        int n = 0;
        while (starts == 0 && n < 400) begin
            tick();
            n++;
        end
        chk("mul_start_seen", (starts != 0), 1'b1);
    endtask

    task automatic pulse_done();
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
    endtask

    initial begin
        int w;
        int bad;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        mul_done = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_we_sel_start_busy", {op_we, op_sel, mul_start, loader_busy}, 4'b0000);
        chk("rst_addr_data", {op_addr, op_wdata}, '0);
        chk("rst_len", {len_a, len_b}, '0);

        // Full load, continuous valid
        mon_clr = 1'b0;
        rst_n   = 1'b1;
        tick();
        chk("first_edge_ready", in_ready, 1'b1);
        chk("idle_busy", loader_busy, 1'b0);
        for (int k = 0; k < NUM_LIMBS; k++) send_beat(64'(k + 1), (k == NUM_LIMBS - 1), 0, w);
        for (int k = 0; k < NUM_LIMBS; k++) send_beat(64'h100 + 64'(k), (k == NUM_LIMBS - 1), 0, w);
        wait_start();
        chk("full_len_a", len_a, 7'd64);
        chk("full_len_b", len_b, 7'd64);
        chk("full_a_writes", a_wr, 64);
        chk("full_b_writes", b_wr, 64);
        bad = 0;
        for (int k = 0; k < NUM_LIMBS; k++) begin
            if (a_mem[k] !== 64'(k + 1)) bad++;
            if (b_mem[k] !== 64'h100 + 64'(k)) bad++;
        end
        chk("full_contents_bad", bad, 0);
        chk("full_order_bad", order_bad, 0);
        chk("full_start_latency", start_cyc - ready_rise_cyc, 129);
        chk("full_start_count", starts, 1);

        // Wait phase: valid held high for 500 cycles, ready must stay low
        clear_mon();
        in_valid = 1'b1;
        in_data  = 64'h5A5A;
        in_last  = 1'b0;
        bad = 0;
        for (int k = 0; k < 500; k++) begin
            if (in_ready !== 1'b0 || op_we !== 1'b0 || loader_busy !== 1'b1) bad++;
            tick();
        end
        chk("wait_ready_low_bad", bad, 0);
        pulse_done();
        chk("done_plus1_ready", in_ready, 1'b0);
        chk("done_plus1_busy", loader_busy, 1'b0);
        tick();
        chk("done_plus2_ready", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("held_beat_write", {op_we, op_sel, op_addr}, {1'b1, SEL_A, 6'd0});
        chk("held_beat_data", op_wdata, 64'h5A5A);

        // Short operands: A = 3 beats, B = 1 beat held through A padding
        send_beat(64'h11, 1'b0, 0, w);
        send_beat(64'h22, 1'b1, 0, w);
        send_beat(64'h77, 1'b1, 0, w);
        chk("pad_a_ready_low_cycles", w, 61);
        wait_start();
        chk("short_len_a", len_a, 7'd3);
        chk("short_len_b", len_b, 7'd1);
        chk("short_a_writes", a_wr, 64);
        chk("short_b_writes", b_wr, 64);
        chk("short_a_head", {a_mem[0], a_mem[1], a_mem[2]}, {64'h5A5A, 64'h11, 64'h22});
        chk("short_b_head", b_mem[0], 64'h77);
        bad = 0;
        for (int k = 3; k < NUM_LIMBS; k++) if (a_mem[k] !== '0) bad++;
        for (int k = 1; k < NUM_LIMBS; k++) if (b_mem[k] !== '0) bad++;
        chk("short_pad_bad", bad, 0);
        chk("short_order_bad", order_bad, 0);
        chk("short_start_count", starts, 1);
        pulse_done();

        // Gapped beats with a stray mul_done during B load
        clear_mon();
        for (int k = 0; k < 5; k++) send_beat(64'h1000 + 64'(k), (k == 4), 1, w);
        send_beat(64'h1100, 1'b0, 1, w);
        pulse_done();
        chk("stray_done_ready", in_ready, 1'b1);
        chk("stray_done_busy", loader_busy, 1'b1);
        for (int k = 1; k < 4; k++) send_beat(64'h1100 + 64'(k), (k == 3), 1, w);
        wait_start();
        chk("gap_len", {len_a, len_b}, {7'd5, 7'd4});
        bad = 0;
        for (int k = 0; k < 5; k++) if (a_mem[k] !== 64'h1000 + 64'(k)) bad++;
        for (int k = 0; k < 4; k++) if (b_mem[k] !== 64'h1100 + 64'(k)) bad++;
        chk("gap_contents_bad", bad, 0);
        chk("gap_writes", {32'(a_wr), 32'(b_wr)}, {32'd64, 32'd64});
        chk("gap_order_bad", order_bad, 0);
        chk("gap_start_count", starts, 1);
        pulse_done();

        // Missing in_last: beat 64 spills into B[0]
        clear_mon();
        for (int k = 0; k < 71; k++) send_beat(64'h2000 + 64'(k), (k == 70), 0, w);
        wait_start();
        chk("nolast_len_a", len_a, 7'd64);
        chk("nolast_len_b", len_b, 7'd7);
        chk("nolast_a63", a_mem[63], 64'h203F);
        chk("nolast_b0_b6", {b_mem[0], b_mem[6], b_mem[7]}, {64'h2040, 64'h2046, 64'h0});
        chk("nolast_writes", {32'(a_wr), 32'(b_wr)}, {32'd64, 32'd64});
        pulse_done();

        // Asynchronous reset in the middle of an A load
        clear_mon();
        for (int k = 0; k < 10; k++) send_beat(64'h3000 + 64'(k), 1'b0, 0, w);
        chk("midload_busy", loader_busy, 1'b1);
        in_valid = 1'b1;
        in_data  = 64'h300A;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", in_ready, 1'b0);
        chk("async_rst_flags", {op_we, op_sel, mul_start, loader_busy}, 4'b0000);
        chk("async_rst_addr_data", {op_addr, op_wdata}, '0);
        chk("async_rst_len", {len_a, len_b}, '0);
        in_valid = 1'b0;
        tick();
        chk("in_rst_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        clear_mon();
        send_beat(64'hAA, 1'b0, 0, w);
        send_beat(64'hBB, 1'b1, 0, w);
        send_beat(64'hCC, 1'b1, 0, w);
        wait_start();
        chk("rst_reload_len", {len_a, len_b}, {7'd2, 7'd1});
        chk("rst_reload_a", {a_mem[0], a_mem[1], a_mem[10]}, {64'hAA, 64'hBB, 64'h0});
        chk("rst_reload_writes", {32'(a_wr), 32'(b_wr)}, {32'd64, 32'd64});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
